// File: rtl/ofdm_frame_buffer_ctrl.sv
// OFDM frame store controller: captures one frame into a single-port RAM, then
// replays it in address order through a 2-entry skid buffer that hides read latency.
module ofdm_frame_buffer_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PLAY    = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  wr_cnt_r, rd_cnt_r;
  logic              inflight_r, inflight_last_r;
  logic [DATA_W-1:0] head_data_r, tail_data_r;
  logic              head_last_r, tail_last_r;
  logic [1:0]        skid_cnt_r;
  logic              done_r;
  logic [ADDR_W-1:0] ram_ad_r;
  logic [DATA_W-1:0] ram_din_r;

  logic              accept_s, pop_s, push_s, rd_issue_s, finish_s;
  logic [1:0]        occ_s;

  // Handshake qualifiers and read-issue decision (occupancy counts this cycle's pop)
  always_comb begin
    accept_s   = (state_r == CAPTURE) && in_valid;
    pop_s      = (skid_cnt_r != 2'd0) && out_ready;
    push_s     = inflight_r;
    occ_s      = skid_cnt_r - {1'b0, pop_s};
    rd_issue_s = (state_r == PLAY) && (rd_cnt_r < FRAME_CNT) &&
                 ((occ_s + {1'b0, inflight_r}) < 2'd2);
    finish_s   = pop_s && head_last_r;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CAPTURE;
        else       state_s = IDLE;
      end
      CAPTURE: begin
        if (accept_s && (wr_cnt_r == LAST_IDX)) state_s = PLAY;
        else                                    state_s = CAPTURE;
      end
      PLAY: begin
        if (finish_s) state_s = IDLE;
        else          state_s = PLAY;
      end
      default: state_s = IDLE;
    endcase
  end

  // RAM port drive; address and data hold their previous value while idle
  always_comb begin
    ram_ce  = accept_s || rd_issue_s;
    ram_wre = accept_s;
    ram_din = ram_din_r;
    ram_ad  = ram_ad_r;
    if (accept_s) begin
      ram_ad  = wr_cnt_r[ADDR_W-1:0];
      ram_din = in_data;
    end else if (rd_issue_s) begin
      ram_ad  = rd_cnt_r[ADDR_W-1:0];
    end else begin
      ram_ad  = ram_ad_r;
    end
  end

  // State, counters, read-in-flight tracking and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      wr_cnt_r        <= '0;
      rd_cnt_r        <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      done_r          <= 1'b0;
      ram_ad_r        <= '0;
      ram_din_r       <= '0;
    end else begin
      state_r         <= state_s;
      inflight_r      <= rd_issue_s;
      inflight_last_r <= rd_issue_s && (rd_cnt_r == LAST_IDX);
      done_r          <= finish_s;
      ram_ad_r        <= ram_ad;
      ram_din_r       <= ram_din;
      if ((state_r == IDLE) && start) wr_cnt_r <= '0;
      else if (accept_s)              wr_cnt_r <= wr_cnt_r + CNT_W'(1);
      if ((state_r == CAPTURE) && (state_s == PLAY)) rd_cnt_r <= '0;
      else if (rd_issue_s)                           rd_cnt_r <= rd_cnt_r + CNT_W'(1);
    end
  end

  // Two-entry skid FIFO; head is the presented entry, tail shifts forward on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_r <= '0;
      tail_data_r <= '0;
      head_last_r <= 1'b0;
      tail_last_r <= 1'b0;
      skid_cnt_r  <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b01: begin
          head_data_r <= tail_data_r;
          head_last_r <= tail_last_r;
          skid_cnt_r  <= skid_cnt_r - 2'd1;
        end
        2'b10: begin
          if (skid_cnt_r == 2'd0) begin
            head_data_r <= ram_dout;
            head_last_r <= inflight_last_r;
          end else begin
            tail_data_r <= ram_dout;
            tail_last_r <= inflight_last_r;
          end
          skid_cnt_r <= skid_cnt_r + 2'd1;
        end
        2'b11: begin
          if (skid_cnt_r == 2'd1) begin
            head_data_r <= ram_dout;
            head_last_r <= inflight_last_r;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= ram_dout;
            tail_last_r <= inflight_last_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign in_ready  = (state_r == CAPTURE);
  assign out_valid = (skid_cnt_r != 2'd0);
  assign out_data  = head_data_r;
  assign out_last  = head_last_r && (skid_cnt_r != 2'd0);
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

endmodule

// File: tb/tb_ofdm_frame_buffer_ctrl.sv
// Bench for ofdm_frame_buffer_ctrl: an 8-sample and a 1024-sample instance, each
// with its own RAM model, checked against a sample-queue reference of the frame.
module tb_ofdm_frame_buffer_ctrl;

  logic        clk;
  logic        rst_n     [2];
  logic        start     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        in_valid  [2];
  logic [15:0] in_data   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [15:0] out_data  [2];
  logic        out_last  [2];
  logic        out_ready [2];
  logic        ram_ce    [2];
  logic        ram_oce   [2];
  logic        ram_reset [2];
  logic        ram_wre   [2];
  logic [9:0]  ram_ad    [2];
  logic [15:0] ram_din   [2];

  int n_total;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int FL = (g == 0) ? 8 : 1024;
    logic [15:0] mem [1024];
    logic [15:0] dout_r;

    ofdm_frame_buffer_ctrl #(.ADDR_W(10), .DATA_W(16), .FRAME_LEN(FL)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .out_valid(out_valid[g]),
      .out_data (out_data[g]),
      .out_last (out_last[g]),
      .out_ready(out_ready[g]),
      .ram_ce   (ram_ce[g]),
      .ram_oce  (ram_oce[g]),
      .ram_reset(ram_reset[g]),
      .ram_wre  (ram_wre[g]),
      .ram_ad   (ram_ad[g]),
      .ram_din  (ram_din[g]),
      .ram_dout (dout_r)
    );

    // Single-port RAM with one-cycle registered read
    always @(posedge clk) begin
      if (ram_ce[g]) begin
        if (ram_wre[g]) mem[ram_ad[g]] <= ram_din[g];
        else            dout_r <= mem[ram_ad[g]];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input int g);
    check_val("rst_busy",      32'(busy[g]),      32'd0);
    check_val("rst_done",      32'(done[g]),      32'd0);
    check_val("rst_in_ready",  32'(in_ready[g]),  32'd0);
    check_val("rst_out_valid", 32'(out_valid[g]), 32'd0);
    check_val("rst_out_last",  32'(out_last[g]),  32'd0);
    check_val("rst_out_data",  32'(out_data[g]),  32'd0);
    check_val("rst_ram_ce",    32'(ram_ce[g]),    32'd0);
    check_val("rst_ram_wre",   32'(ram_wre[g]),   32'd0);
    check_val("rst_ram_ad",    32'(ram_ad[g]),    32'd0);
    check_val("rst_ram_din",   32'(ram_din[g]),   32'd0);
    check_val("rst_ram_oce",   32'(ram_oce[g]),   32'd1);
    check_val("rst_ram_reset", 32'(ram_reset[g]), 32'd0);
  endtask

  // One frame: capture then playback; abort_at>=0 resets after that many outputs
  task automatic run_frame(input int g, input bit gaps, input bit rnd_rdy,
                           input bit noise_start, input bit seq_data, input int abort_at);
    int fl;
    logic [15:0] frame [$];
    logic [15:0] d;
    int wr, guard, issued, iss_prev, iss_now, popped, c;
    bit pop_now;
    fl = (g == 0) ? 8 : 1024;
    wr = 0; guard = 0; issued = 0; iss_prev = 0; popped = 0; c = 0;

    @(negedge clk);
    check_val("idle_busy", 32'(busy[g]), 32'd0);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    while (wr < fl && guard < 8 * fl + 100) begin
      in_valid[g] = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      d = seq_data ? 16'(32'h1000 + wr) : 16'($urandom);
      in_data[g] = d;
      start[g] = noise_start ? ($urandom_range(0, 1) == 1) : 1'b0;
      #1;
      check_val("cap_in_ready", 32'(in_ready[g]), 32'd1);
      check_val("cap_busy",     32'(busy[g]),     32'd1);
      check_val("cap_wre",      32'(ram_wre[g]),  32'(in_valid[g]));
      check_val("cap_ce",       32'(ram_ce[g]),   32'(in_valid[g]));
      if (in_valid[g]) begin
        check_val("cap_ad",  32'(ram_ad[g]),  32'(wr % 1024));
        check_val("cap_din", 32'(ram_din[g]), 32'(d));
        frame.push_back(d);
        wr++;
      end
      @(negedge clk);
      guard++;
    end
    if (wr < fl) check_val("cap_timeout", 32'(wr), 32'(fl));

    while (popped < fl && c < 8 * fl + 100) begin
      in_valid[g]  = 1'b0;
      start[g]     = noise_start ? ($urandom_range(0, 1) == 1) : 1'b0;
      out_ready[g] = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (abort_at >= 0 && popped == abort_at) begin
        out_ready[g] = 1'b0;
        start[g]     = 1'b0;
        rst_n[g]     = 1'b0;
        #1;
        check_reset_vals(g);
        @(negedge clk);
        rst_n[g] = 1'b1;
        #1;
        check_val("abort_no_done", 32'(done[g]), 32'd0);
        check_val("abort_idle",    32'(busy[g]), 32'd0);
        return;
      end
      #1;
      iss_now = issued;
      check_val("play_in_ready", 32'(in_ready[g]), 32'd0);
      check_val("play_wre",      32'(ram_wre[g]),  32'd0);
      check_val("play_busy",     32'(busy[g]),     32'd1);
      check_val("play_done",     32'(done[g]),     32'd0);
      check_val("play_valid",    32'(out_valid[g]), 32'(iss_prev > popped));
      pop_now = out_valid[g] && out_ready[g];
      if (ram_ce[g]) begin
        check_val("rd_ad",    32'(ram_ad[g]), 32'(issued % 1024));
        check_val("rd_range", 32'(issued < fl), 32'd1);
        check_val("rd_room",  32'((issued - popped - int'(pop_now)) < 2), 32'd1);
        issued++;
      end
      if (pop_now) begin
        check_val("out_data", 32'(out_data[g]), 32'(frame[popped]));
        check_val("out_last", 32'(out_last[g]), 32'(popped == fl - 1));
        if (!rnd_rdy) check_val("out_latency", 32'(c), 32'(popped + 2));
        popped++;
      end
      iss_prev = iss_now;
      @(negedge clk);
      c++;
    end
    if (popped < fl) check_val("play_timeout", 32'(popped), 32'(fl));
    out_ready[g] = 1'b1;
    start[g]     = 1'b0;
    #1;
    check_val("done_pulse", 32'(done[g]),      32'd1);
    check_val("done_busy",  32'(busy[g]),      32'd0);
    check_val("done_empty", 32'(out_valid[g]), 32'd0);
    check_val("done_ce",    32'(ram_ce[g]),    32'd0);
    @(negedge clk);
    #1;
    check_val("done_once", 32'(done[g]), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i]     = 1'b0;
      start[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_data[i]   = 16'h0000;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    run_frame(0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    run_frame(1, 1'b1, 1'b1, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
